// File: rtl/eq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | eq_pkg : shared defaults, clog2 helper, sweep FSM encoding       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package eq_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_TAPS     = 64;
    localparam int DEF_CHANNELS = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

    typedef logic signed [DEF_DATA_W-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/history_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | history_bank : CHANNELS x TAPS sample store, one write port and  |
// | two registered read ports (primary / pair).  Rev 1.0             |
// +------------------------------------------------------------------+
module history_bank
    import eq_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int TAPS     = DEF_TAPS,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int CH_W     = 1,
    parameter int IDX_W    = 6
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [CH_W-1:0]          wr_channel,
    input  logic [IDX_W-1:0]         wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     rd_en,
    input  logic [CH_W-1:0]          rd_channel,
    input  logic [IDX_W-1:0]         rd_addr,
    input  logic [IDX_W-1:0]         rd_pair_addr,
    output logic signed [DATA_W-1:0] rd_data,
    output logic signed [DATA_W-1:0] rd_pair_data
);

    logic [DATA_W-1:0] mem [CHANNELS][TAPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int t = 0; t < TAPS; t++) begin
                    mem[c][t] <= '0;
                end
            end
            rd_data      <= '0;
            rd_pair_data <= '0;
        end else if (clear) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int t = 0; t < TAPS; t++) begin
                    mem[c][t] <= '0;
                end
            end
            rd_data      <= '0;
            rd_pair_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_channel][wr_addr] <= wr_data;
            end
            // Read registers hold while stalled so the tap outputs stay stable.
            if (rd_en) begin
                rd_data      <= mem[rd_channel][rd_addr];
                rd_pair_data <= mem[rd_channel][rd_pair_addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_tap_history.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fir_tap_history : multi-channel circular FIR delay line that     |
// | streams each channel's history (optionally folded). Rev 1.0      |
// +------------------------------------------------------------------+
module fir_tap_history
    import eq_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int TAPS     = DEF_TAPS,
    parameter  int CHANNELS = DEF_CHANNELS,
    localparam int CH_W     = (clog2(CHANNELS) > 1) ? clog2(CHANNELS) : 1,
    localparam int IDX_W    = clog2(TAPS)
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     sym_mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_W-1:0]          in_channel,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     tap_valid,
    input  logic                     tap_ready,
    output logic [CH_W-1:0]          tap_channel,
    output logic [IDX_W-1:0]         tap_index,
    output logic                     tap_first,
    output logic                     tap_last,
    output logic signed [DATA_W-1:0] tap_data,
    output logic signed [DATA_W-1:0] tap_data_pair
);

    localparam logic [IDX_W-1:0] LAST_FULL = IDX_W'(TAPS - 1);
    localparam logic [IDX_W-1:0] LAST_SYM  = IDX_W'(TAPS / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W:0]   TAPS_EXT  = (IDX_W + 1)'(TAPS);
    localparam logic [IDX_W:0]   ONE_EXT   = (IDX_W + 1)'(1);
    localparam logic [CH_W:0]    CH_LIMIT  = (CH_W + 1)'(CHANNELS);

    sweep_state_t state, state_nxt;

    logic [IDX_W-1:0] wr_ptr [CHANNELS];
    logic [IDX_W-1:0] newest;
    logic [CH_W-1:0]  sweep_ch;
    logic             sweep_sym;

    // Issue stage: next tap index to fetch.
    logic             issuing;
    logic [IDX_W-1:0] issue_k;

    // Fetch stage: registered bank addresses for one beat.
    logic             fetch_valid;
    logic [IDX_W-1:0] fetch_k;
    logic [IDX_W-1:0] fetch_addr;
    logic [IDX_W-1:0] fetch_pair_addr;
    logic             fetch_last;

    logic             out_sym;
    logic signed [DATA_W-1:0] bank_pair;

    logic             accept;
    logic             ch_in_range;
    logic             advance;
    logic             issue_last;
    logic [IDX_W-1:0] last_k;
    logic [IDX_W-1:0] addr_calc;
    logic [IDX_W-1:0] pair_calc;
    logic [IDX_W:0]   back_sum;
    logic [IDX_W:0]   fwd_sum;
    logic [IDX_W:0]   fwd_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && ch_in_range) state_nxt = SWEEP;
            end
            SWEEP: begin
                if (tap_valid && tap_ready && tap_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept      = in_valid & in_ready;
        ch_in_range = {1'b0, in_channel} < CH_LIMIT;
        advance     = !tap_valid || tap_ready;
        last_k      = sweep_sym ? LAST_SYM : LAST_FULL;
        issue_last  = (issue_k == last_k);

        // Delay k looks backwards from the newest slot, wrapping by compare.
        back_sum = '0;
        if (newest >= issue_k) begin
            addr_calc = newest - issue_k;
        end else begin
            back_sum  = {1'b0, newest} + TAPS_EXT - {1'b0, issue_k};
            addr_calc = back_sum[IDX_W-1:0];
        end

        // Pair tap walks forwards from the oldest slot (newest + 1).
        fwd_sum  = {1'b0, newest} + {1'b0, issue_k} + ONE_EXT;
        fwd_wrap = (fwd_sum >= TAPS_EXT) ? (fwd_sum - TAPS_EXT) : fwd_sum;
        pair_calc = fwd_wrap[IDX_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) wr_ptr[c] <= '0;
        end else if (clear) begin
            for (int c = 0; c < CHANNELS; c++) wr_ptr[c] <= '0;
        end else if (accept && ch_in_range) begin
            wr_ptr[in_channel] <= (wr_ptr[in_channel] == LAST_FULL) ? '0
                                                                   : wr_ptr[in_channel] + IDX_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            newest          <= '0;
            sweep_ch        <= '0;
            sweep_sym       <= 1'b0;
            issuing         <= 1'b0;
            issue_k         <= '0;
            fetch_valid     <= 1'b0;
            fetch_k         <= '0;
            fetch_addr      <= '0;
            fetch_pair_addr <= '0;
            fetch_last      <= 1'b0;
            tap_valid       <= 1'b0;
            tap_index       <= '0;
            tap_first       <= 1'b0;
            tap_last        <= 1'b0;
            tap_channel     <= '0;
            out_sym         <= 1'b0;
        end else if (clear) begin
            newest          <= '0;
            sweep_ch        <= '0;
            sweep_sym       <= 1'b0;
            issuing         <= 1'b0;
            issue_k         <= '0;
            fetch_valid     <= 1'b0;
            fetch_k         <= '0;
            fetch_addr      <= '0;
            fetch_pair_addr <= '0;
            fetch_last      <= 1'b0;
            tap_valid       <= 1'b0;
            tap_index       <= '0;
            tap_first       <= 1'b0;
            tap_last        <= 1'b0;
            tap_channel     <= '0;
            out_sym         <= 1'b0;
        end else begin
            if (accept && ch_in_range) begin
                newest    <= wr_ptr[in_channel];
                sweep_ch  <= in_channel;
                sweep_sym <= sym_mode;
                issuing   <= 1'b1;
                issue_k   <= '0;
            end else if (advance) begin
                fetch_valid <= issuing;
                if (issuing) begin
                    fetch_k         <= issue_k;
                    fetch_addr      <= addr_calc;
                    fetch_pair_addr <= pair_calc;
                    fetch_last      <= issue_last;
                    issue_k         <= issue_k + IDX_ONE;
                    issuing         <= !issue_last;
                end
            end

            if (advance) begin
                tap_valid <= fetch_valid;
                if (fetch_valid) begin
                    tap_index   <= fetch_k;
                    tap_first   <= (fetch_k == '0);
                    tap_last    <= fetch_last;
                    tap_channel <= sweep_ch;
                    out_sym     <= sweep_sym;
                end
            end
        end
    end

    history_bank #(
        .DATA_W   (DATA_W),
        .TAPS     (TAPS),
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .wr_en        (accept && ch_in_range),
        .wr_channel   (in_channel),
        .wr_addr      (wr_ptr[in_channel]),
        .wr_data      (in_data),
        .rd_en        (advance && fetch_valid),
        .rd_channel   (sweep_ch),
        .rd_addr      (fetch_addr),
        .rd_pair_addr (fetch_pair_addr),
        .rd_data      (tap_data),
        .rd_pair_data (bank_pair)
    );

    assign tap_data_pair = out_sym ? bank_pair : '0;

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_history.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fir_tap_history : randomized bench against a newest-first     |
// | history model per channel.  Rev 1.0                              |
// +------------------------------------------------------------------+
module tb_fir_tap_history;

    localparam int TAPS     = 8;
    localparam int CHANNELS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic sym_mode = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [0:0] in_channel = '0;
    logic signed [15:0] in_data = '0;
    logic tap_valid;
    logic tap_ready = 1'b1;
    logic [0:0] tap_channel;
    logic [2:0] tap_index;
    logic tap_first;
    logic tap_last;
    logic signed [15:0] tap_data;
    logic signed [15:0] tap_data_pair;

    // Three-channel instance so an out-of-range channel id is representable.
    logic oor_in_valid = 1'b0;
    logic oor_in_ready;
    logic [1:0] oor_in_channel = '0;
    logic signed [15:0] oor_in_data = '0;
    logic oor_tap_valid;
    logic [1:0] oor_tap_channel;
    logic [2:0] oor_tap_index;
    logic oor_tap_first;
    logic oor_tap_last;
    logic signed [15:0] oor_tap_data;
    logic signed [15:0] oor_tap_data_pair;

    int n_checks = 0;
    int n_errors = 0;
    int hist [CHANNELS][TAPS];

    fir_tap_history #(.DATA_W(16), .TAPS(TAPS), .CHANNELS(CHANNELS)) dut (
        .clk(clk), .rst(rst), .clear(clear), .sym_mode(sym_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_channel(in_channel), .in_data(in_data),
        .tap_valid(tap_valid), .tap_ready(tap_ready), .tap_channel(tap_channel),
        .tap_index(tap_index), .tap_first(tap_first), .tap_last(tap_last),
        .tap_data(tap_data), .tap_data_pair(tap_data_pair)
    );

    fir_tap_history #(.DATA_W(16), .TAPS(TAPS), .CHANNELS(3)) dut_oor (
        .clk(clk), .rst(rst), .clear(1'b0), .sym_mode(1'b0),
        .in_valid(oor_in_valid), .in_ready(oor_in_ready), .in_channel(oor_in_channel),
        .in_data(oor_in_data), .tap_valid(oor_tap_valid), .tap_ready(1'b1),
        .tap_channel(oor_tap_channel), .tap_index(oor_tap_index), .tap_first(oor_tap_first),
        .tap_last(oor_tap_last), .tap_data(oor_tap_data), .tap_data_pair(oor_tap_data_pair)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input int c, input int d);
        for (int i = TAPS - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
        hist[c][0] = d;
    endtask

    task automatic model_clear();
        for (int c = 0; c < CHANNELS; c++)
            for (int i = 0; i < TAPS; i++) hist[c][i] = 0;
    endtask

    task automatic push(input int ch, input int d, input bit sym);
        int b;
        in_channel = 1'(ch);
        in_data    = 16'(d);
        sym_mode   = sym;
        in_valid   = 1'b1;
        b = 0;
        while (!in_ready && b < 50) begin
            tick();
            b++;
        end
        check("push_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        model_push(ch, d);
    endtask

    // mode: 0 gapless, 1 random backpressure, 2 stall 3 cycles at k=3 with
    // in_valid held high, 3 clear at k=4, 4 rst at k=4
    task automatic run_sweep(input int ch, input bit sym, input int mode);
        int n;
        int k;
        int stall;
        int budget;
        bit r;
        n = sym ? TAPS / 2 : TAPS;
        k = 0;
        stall = 0;
        budget = 0;
        check("lat_e0_valid", int'(tap_valid), 0);
        check("lat_e0_busy", int'(in_ready), 0);
        tick();
        check("lat_e1_valid", int'(tap_valid), 0);
        tick();
        check("lat_e2_valid", int'(tap_valid), 1);
        if (mode == 2) begin
            in_valid   = 1'b1;
            in_channel = 1'b0;
            in_data    = 16'sd1234;
        end
        while (k < n && budget < 200) begin
            if ((mode == 3 || mode == 4) && k == 4) begin
                if (mode == 3) clear = 1'b1;
                else           rst   = 1'b1;
                tick();
                clear = 1'b0;
                rst   = 1'b0;
                check("abort_valid", int'(tap_valid), 0);
                check("abort_ready", int'(in_ready), 1);
                check("abort_data", int'(tap_data), 0);
                model_clear();
                tap_ready = 1'b1;
                return;
            end
            case (mode)
                1:       r = ($urandom_range(0, 3) != 0);
                2:       r = !(k == 3 && stall < 3);
                default: r = 1'b1;
            endcase
            if (!r) stall++;
            if (mode == 2 && r && k == n - 1) in_valid = 1'b0;
            tap_ready = r;
            check("busy", int'(in_ready), 0);
            check("valid", int'(tap_valid), 1);
            check("index", int'(tap_index), k);
            check("first", int'(tap_first), int'(k == 0));
            check("last", int'(tap_last), int'(k == n - 1));
            check("chan", int'(tap_channel), ch);
            check("data", int'(tap_data), hist[ch][k]);
            check("pair", int'(tap_data_pair), sym ? hist[ch][TAPS-1-k] : 0);
            tick();
            budget++;
            if (r) k++;
        end
        check("sweep_beats", k, n);
        tap_ready = 1'b1;
        in_valid  = 1'b0;
        check("end_valid", int'(tap_valid), 0);
        check("end_ready", int'(in_ready), 1);
    endtask

    initial begin
        int c;
        int d;
        bit s;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        check("rst_valid", int'(tap_valid), 0);
        check("rst_first", int'(tap_first), 0);
        check("rst_last", int'(tap_last), 0);
        check("rst_index", int'(tap_index), 0);
        check("rst_chan", int'(tap_channel), 0);
        check("rst_data", int'(tap_data), 0);
        check("rst_pair", int'(tap_data_pair), 0);
        check("rst_ready", int'(in_ready), 1);

        // Single impulse into a fresh history.
        push(0, 100, 1'b0);
        run_sweep(0, 1'b0, 0);

        // Ramp long enough to wrap the write pointer.
        for (int i = 1; i <= 10; i++) begin
            push(0, i, 1'b0);
            run_sweep(0, 1'b0, i % 2);
        end

        // Folded sweep after 1..8.
        for (int i = 1; i <= 8; i++) begin
            push(0, i, i == 8);
            run_sweep(0, i == 8, 0);
        end

        // Channel isolation.
        push(1, -5, 1'b0);
        run_sweep(1, 1'b0, 0);
        push(0, 33, 1'b0);
        run_sweep(0, 1'b0, 0);
        push(1, -6, 1'b0);
        run_sweep(1, 1'b0, 0);
        push(0, 44, 1'b1);
        run_sweep(0, 1'b1, 1);

        // Out-of-range channel is swallowed without a sweep.
        oor_in_channel = 2'd3;
        oor_in_data    = 16'sd77;
        oor_in_valid   = 1'b1;
        tick();
        oor_in_valid = 1'b0;
        check("oor_ready", int'(oor_in_ready), 1);
        check("oor_valid0", int'(oor_tap_valid), 0);
        tick();
        tick();
        check("oor_valid2", int'(oor_tap_valid), 0);
        check("oor_ready2", int'(oor_in_ready), 1);
        oor_in_channel = 2'd2;
        oor_in_data    = 16'sd9;
        oor_in_valid   = 1'b1;
        tick();
        oor_in_valid = 1'b0;
        tick();
        tick();
        check("oor_ch2_valid", int'(oor_tap_valid), 1);
        check("oor_ch2_chan", int'(oor_tap_channel), 2);
        check("oor_ch2_data", int'(oor_tap_data), 9);
        tick();
        check("oor_ch2_data1", int'(oor_tap_data), 0);
        repeat (8) tick();
        check("oor_ch2_done", int'(oor_in_ready), 1);

        // Backpressure at k=3 with a pending input.
        push(0, 55, 1'b0);
        run_sweep(0, 1'b0, 2);

        // Abort by clear, then by rst.
        push(0, 66, 1'b0);
        run_sweep(0, 1'b0, 3);
        push(0, 7, 1'b0);
        run_sweep(0, 1'b0, 0);
        push(1, 88, 1'b0);
        run_sweep(1, 1'b0, 4);
        push(0, 7, 1'b0);
        run_sweep(0, 1'b0, 0);

        // Random traffic with random backpressure.
        repeat (40) begin
            c = int'($urandom_range(0, CHANNELS - 1));
            d = int'($urandom_range(0, 65535)) - 32768;
            s = 1'($urandom_range(0, 1));
            push(c, d, s);
            run_sweep(c, s, 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
